// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the default bus widths, the word size and the queue entry layout.
// Fetch-stage modules import this package.
package fetch_pkg;

  localparam int PC_WIDTH_DEF   = 8;
  localparam int INST_WIDTH_DEF = 32;
  localparam int WORD_BYTES     = 4;

  // One fetched instruction tagged with the byte address it came from.
  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]   pc;
    logic [INST_WIDTH_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: 2-entry in-order queue of fetched {pc, inst} entries.
// Latency: a pushed entry is visible at the head after the push edge.
// Backpressure: no internal stall; the caller keeps pushes within capacity.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output fetch_entry_t head_dat,
  output logic [1:0]   count
);

  fetch_entry_t [1:0] mem_q, mem_d;
  logic [1:0]         count_q, count_d;
  logic               pop_ok;
  logic [1:0]         wr_pos;

  // Next-state: flush wins; otherwise shift on pop and write behind the survivor.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    wr_pos  = count_q - {1'b0, pop_ok};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        mem_d[0] = mem_q[1];
      end
      if (push) begin
        mem_d[wr_pos[0]] = push_dat;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head_dat = mem_q[0];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Purpose: owns the PC, issues reads to a 1-cycle imem and hands {pc, inst} to decode.
// Latency: first word is valid after the second edge out of reset or after a redirect.
// Backpressure: out_valid/out_ready; requests stop once queued plus in-flight words reach 2.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
  parameter int                  INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [PC_WIDTH-1:0]   out_pc_plus4
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(WORD_BYTES);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          q_count;
  logic [2:0]          fill;
  logic                pop, push;
  fetch_entry_t        head, push_ent;

  assign pop  = out_valid & out_ready;
  assign fill = {1'b0, q_count} + {2'b00, inflight_q};

  // Credit check: a slot must be free counting the word already in flight and
  // any entry decode takes this cycle, so a return can never overflow the queue.
  assign imem_req  = rst_n & ~redirect_valid & (fill < (3'd2 + {2'b00, pop}));
  assign imem_addr = pc_q;

  // A redirect discards the in-flight word; otherwise the returned word is queued.
  assign push         = inflight_q & ~redirect_valid;
  assign push_ent.pc   = inflight_pc_q;
  assign push_ent.inst = imem_rdata;

  // PC and in-flight tracking: redirect overrides issue.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    end else if (imem_req) begin
      pc_d          = pc_q + STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  // PC and in-flight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head),
    .count    (q_count)
  );

  // Data outputs read as zero whenever nothing is offered.
  assign out_valid    = (q_count != 2'd0);
  assign out_inst     = out_valid ? head.inst : '0;
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_pc_plus4 = out_valid ? head.pc + STEP : '0;

endmodule
